// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Package  : i2c_pkg
// Purpose  : Shared types for the I2C transaction sequencer: byte-engine
//            command codes and the sequencer state encoding.
// Revision : 1.0  initial release
//==============================================================================
package i2c_pkg;

  // Command codes understood by the bit-level byte engine.
  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } eng_cmd_t;

  // *_ISS states present a command to the engine, *_WT states wait for
  // the engine to report completion.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_ISS = 4'd1,
    ST_START_WT  = 4'd2,
    ST_ADDR_ISS  = 4'd3,
    ST_ADDR_WT   = 4'd4,
    ST_TX_LOAD   = 4'd5,
    ST_WR_ISS    = 4'd6,
    ST_WR_WT     = 4'd7,
    ST_RD_ISS    = 4'd8,
    ST_RD_WT     = 4'd9,
    ST_RX_PUSH   = 4'd10,
    ST_STOP_ISS  = 4'd11,
    ST_STOP_WT   = 4'd12
  } seq_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_transaction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : i2c_transaction_sequencer
// Purpose  : Master-side transaction controller. On a GO pulse it issues
//            START, address byte, N data bytes and STOP to the byte engine,
//            draining the TX FIFO (write) or filling the RX FIFO (read), and
//            reports busy / done / NACK / arbitration-loss status.
// Ports    : pclk, n_rst (async, active-low)
//            go, abort, cfg_rw, cfg_addr[6:0], cfg_count[CNT_W-1:0]  - control
//            tx_empty, tx_data[7:0] -> tx_pop                        - TX FIFO
//            rx_full -> rx_push, rx_data[7:0]                         - RX FIFO
//            eng_valid, eng_cmd[1:0], eng_wdata[7:0], eng_nack_last,
//            eng_ready, eng_done, eng_ack, eng_rdata[7:0], eng_arb_lost
//                                                                - byte engine
//            status_clear -> busy, done_flag, nack_flag, arb_flag     - status
// Revision : 1.0  initial release
//==============================================================================
module i2c_transaction_sequencer
  import i2c_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             pclk,
  input  logic             n_rst,
  input  logic             go,
  input  logic             abort,
  input  logic             cfg_rw,
  input  logic [6:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             tx_empty,
  input  logic [7:0]       tx_data,
  output logic             tx_pop,
  input  logic             rx_full,
  output logic             rx_push,
  output logic [7:0]       rx_data,
  output logic             eng_valid,
  output logic [1:0]       eng_cmd,
  output logic [7:0]       eng_wdata,
  output logic             eng_nack_last,
  input  logic             eng_ready,
  input  logic             eng_done,
  input  logic             eng_ack,
  input  logic [7:0]       eng_rdata,
  input  logic             eng_arb_lost,
  input  logic             status_clear,
  output logic             busy,
  output logic             done_flag,
  output logic             nack_flag,
  output logic             arb_flag
);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_rw;
  logic [6:0]       r_addr;
  logic [7:0]       r_wbyte;
  logic [7:0]       r_rbyte;
  logic             r_abort;
  logic             r_done, r_nack, r_arb;

  eng_cmd_t w_cmd;
  logic     w_latch_cfg, w_dec, w_cap_tx, w_cap_rx;
  logic     w_set_done, w_set_nack, w_set_arb;
  logic     w_abort_any;
  logic     w_abort_ok;

  // A pulse arriving in the very cycle of a *_WT exit still counts.
  assign w_abort_any = r_abort | abort;
  assign w_abort_ok  = (r_state != ST_IDLE) && (r_state != ST_STOP_ISS) &&
                       (r_state != ST_STOP_WT);

  //--------------------------------------------------------------------------
  // Next state and outputs
  //--------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_cmd         = CMD_START;
    eng_valid     = 1'b0;
    eng_wdata     = 8'h00;
    eng_nack_last = 1'b0;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    w_latch_cfg   = 1'b0;
    w_dec         = 1'b0;
    w_cap_tx      = 1'b0;
    w_cap_rx      = 1'b0;
    w_set_done    = 1'b0;
    w_set_nack    = 1'b0;
    w_set_arb     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_latch_cfg = 1'b1;
          w_next      = ST_START_ISS;
        end
      end
      ST_START_ISS: begin
        eng_valid = 1'b1;
        w_cmd     = CMD_START;
        if (eng_ready) w_next = ST_START_WT;
      end
      ST_START_WT: begin
        if (eng_done) w_next = w_abort_any ? ST_STOP_ISS : ST_ADDR_ISS;
      end
      ST_ADDR_ISS: begin
        eng_valid = 1'b1;
        w_cmd     = CMD_WRITE;
        eng_wdata = {r_addr, r_rw};
        if (eng_ready) w_next = ST_ADDR_WT;
      end
      ST_ADDR_WT: begin
        if (eng_done) begin
          if (!eng_ack) begin
            w_set_nack = 1'b1;
            w_next     = ST_STOP_ISS;
          end else if (w_abort_any || (r_count == c_cnt_zero)) begin
            w_next = ST_STOP_ISS;
          end else begin
            w_next = r_rw ? ST_RD_ISS : ST_TX_LOAD;
          end
        end
      end
      ST_TX_LOAD: begin
        // The engine keeps the bus stretched while the FIFO is refilled.
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          w_cap_tx = 1'b1;
          w_next   = ST_WR_ISS;
        end
      end
      ST_WR_ISS: begin
        eng_valid = 1'b1;
        w_cmd     = CMD_WRITE;
        eng_wdata = r_wbyte;
        if (eng_ready) w_next = ST_WR_WT;
      end
      ST_WR_WT: begin
        if (eng_done) begin
          w_dec = 1'b1;
          if (!eng_ack) begin
            w_set_nack = 1'b1;
            w_next     = ST_STOP_ISS;
          end else if (w_abort_any || (r_count <= c_cnt_one)) begin
            w_next = ST_STOP_ISS;
          end else begin
            w_next = ST_TX_LOAD;
          end
        end
      end
      ST_RD_ISS: begin
        eng_valid     = 1'b1;
        w_cmd         = CMD_READ;
        eng_nack_last = (r_count == c_cnt_one);
        if (eng_ready) w_next = ST_RD_WT;
      end
      ST_RD_WT: begin
        if (eng_done) begin
          w_dec    = 1'b1;
          w_cap_rx = 1'b1;
          w_next   = w_abort_any ? ST_STOP_ISS : ST_RX_PUSH;
        end
      end
      ST_RX_PUSH: begin
        if (!rx_full) begin
          rx_push = 1'b1;
          // Counter was already decremented on the READ completion.
          w_next  = (r_count != c_cnt_zero) ? ST_RD_ISS : ST_STOP_ISS;
        end
      end
      ST_STOP_ISS: begin
        eng_valid = 1'b1;
        w_cmd     = CMD_STOP;
        if (eng_ready) w_next = ST_STOP_WT;
      end
      ST_STOP_WT: begin
        if (eng_done) begin
          w_set_done = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase

    // Losing arbitration abandons the bus at once: no STOP, no FIFO traffic,
    // and it overrides anything a simultaneous eng_done would have done.
    if ((r_state != ST_IDLE) && eng_arb_lost) begin
      w_next     = ST_IDLE;
      w_set_arb  = 1'b1;
      w_set_done = 1'b0;
      w_set_nack = 1'b0;
      w_dec      = 1'b0;
      w_cap_tx   = 1'b0;
      w_cap_rx   = 1'b0;
      tx_pop     = 1'b0;
      rx_push    = 1'b0;
    end
  end

  assign eng_cmd   = w_cmd;
  assign rx_data   = r_rbyte;
  assign busy      = (r_state != ST_IDLE);
  assign done_flag = r_done;
  assign nack_flag = r_nack;
  assign arb_flag  = r_arb;

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wbyte <= '0;
      r_rbyte <= '0;
      r_abort <= 1'b0;
      r_done  <= 1'b0;
      r_nack  <= 1'b0;
      r_arb   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_latch_cfg) begin
        r_rw    <= cfg_rw;
        r_addr  <= cfg_addr;
        r_count <= cfg_count;
      end else if (w_dec && (r_count != c_cnt_zero)) begin
        r_count <= r_count - c_cnt_one;
      end

      if (w_cap_tx) r_wbyte <= tx_data;
      if (w_cap_rx) r_rbyte <= eng_rdata;

      // Pending abort is consumed once the STOP path (or IDLE) is reached.
      if ((w_next == ST_STOP_ISS) || (w_next == ST_IDLE)) r_abort <= 1'b0;
      else if (abort && w_abort_ok)                        r_abort <= 1'b1;

      // Sticky flags: a set in the same cycle as a clear wins.
      if (w_set_done)        r_done <= 1'b1;
      else if (status_clear) r_done <= 1'b0;
      if (w_set_nack)        r_nack <= 1'b1;
      else if (status_clear) r_nack <= 1'b0;
      if (w_set_arb)         r_arb  <= 1'b1;
      else if (status_clear) r_arb  <= 1'b0;
    end
  end

endmodule : i2c_transaction_sequencer
`default_nettype wire

// File: tb/tb_i2c_transaction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_i2c_transaction_sequencer
// Purpose  : Self-checking bench: behavioural byte engine and FIFOs, a
//            transaction-level reference model, a vector table, directed
//            corner sequences and randomized transactions.
// Revision : 1.0  initial release
//==============================================================================
module tb_i2c_transaction_sequencer;

  localparam int CNT_W = 6;
  localparam logic [1:0] c_start = 2'b00, c_write = 2'b01, c_read = 2'b10, c_stop = 2'b11;

  logic pclk = 1'b0, n_rst = 1'b0;
  logic go = 0, abort = 0, cfg_rw = 0, tx_empty = 1, rx_full = 0;
  logic [6:0] cfg_addr = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic [7:0] tx_data = '0, eng_rdata = '0;
  logic eng_ready = 0, eng_done = 0, eng_ack = 0, eng_arb_lost = 0, status_clear = 0;
  logic tx_pop, rx_push, eng_valid, eng_nack_last, busy, done_flag, nack_flag, arb_flag;
  logic [7:0] rx_data, eng_wdata;
  logic [1:0] eng_cmd;

  always #5 pclk = ~pclk;

  i2c_transaction_sequencer #(.CNT_W(CNT_W)) dut (
    .pclk(pclk), .n_rst(n_rst), .go(go), .abort(abort), .cfg_rw(cfg_rw),
    .cfg_addr(cfg_addr), .cfg_count(cfg_count), .tx_empty(tx_empty),
    .tx_data(tx_data), .tx_pop(tx_pop), .rx_full(rx_full), .rx_push(rx_push),
    .rx_data(rx_data), .eng_valid(eng_valid), .eng_cmd(eng_cmd),
    .eng_wdata(eng_wdata), .eng_nack_last(eng_nack_last), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata),
    .eng_arb_lost(eng_arb_lost), .status_clear(status_clear), .busy(busy),
    .done_flag(done_flag), .nack_flag(nack_flag), .arb_flag(arb_flag)
  );

  typedef struct packed { logic [1:0] cmd; logic [7:0] wdata; logic nl; } cmd_rec_t;
  typedef struct {
    logic rw; logic [6:0] addr; int cnt; int nk;
    int e_ncmd; int e_pops; int e_push; logic e_nack;
  } vec_t;

  cmd_rec_t   cmdlog[$], exp_cmds[$];
  logic [7:0] tx_q[$], rd_q[$], popped[$], pushed[$], exp_pops[$], exp_push[$];
  logic [7:0] txsrc[$], rxsrc[$];
  logic       exp_nack;

  int n_cmp = 0, n_bad = 0;

  // engine / environment knobs and state
  bit   eng_busy = 0, rdy_rand = 1, stall_rand = 0;
  logic [1:0] eng_cur = '0;
  int   eng_cnt = 0, w_idx = 0, nack_idx = -1, done_lat = 0, rx_full_cnt = 0;

  // samples taken #2 after each rising edge
  logic s_valid = 0, s_accept = 0, s_nl = 0, s_pop = 0, s_push = 0, s_busy = 0;
  logic s_done_f = 0, s_nack_f = 0, s_arb_f = 0;
  logic [1:0] s_cmd = '0;
  logic [7:0] s_wdata = '0, s_txd = '0, s_rxd = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: commit what happened at the edge, drive new inputs, sample.
  task automatic tick();
    cmd_rec_t r;
    logic p_valid, p_accept;
    logic [1:0] p_cmd;
    logic [7:0] p_wdata;
    p_valid = s_valid; p_accept = s_accept; p_cmd = s_cmd; p_wdata = s_wdata;
    @(posedge pclk); #1;
    if (eng_arb_lost) eng_busy = 0;
    go = 0; abort = 0; status_clear = 0; eng_arb_lost = 0;
    eng_done = 0; eng_ready = 0; eng_ack = 0;
    if (s_pop) begin
      popped.push_back(s_txd);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (s_push) pushed.push_back(s_rxd);
    if (s_accept) begin
      r.cmd = s_cmd; r.wdata = s_wdata; r.nl = s_nl;
      cmdlog.push_back(r);
      eng_busy = 1; eng_cur = s_cmd;
      eng_cnt = (done_lat > 0) ? done_lat - 1 : int'($urandom_range(0, 2));
      if (s_cmd == c_start) w_idx = 0;
    end
    if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_done = 1; eng_busy = 0;
        if (eng_cur == c_write) begin
          eng_ack = (w_idx != nack_idx);
          w_idx++;
        end else if (eng_cur == c_read) begin
          if (rd_q.size() > 0) eng_rdata = rd_q.pop_front();
          else eng_rdata = 8'hEE;
        end
      end else eng_cnt--;
    end else if (eng_valid && (!rdy_rand || $urandom_range(0, 9) < 6)) begin
      eng_ready = 1;
    end
    tx_empty = (tx_q.size() == 0) || (stall_rand && $urandom_range(0, 3) == 0);
    tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    if (rx_full_cnt > 0) begin rx_full = 1; rx_full_cnt--; end
    else rx_full = stall_rand && ($urandom_range(0, 3) == 0);
    #1;
    if (p_valid && !p_accept && eng_valid) begin
      chk("hold_cmd", {30'd0, eng_cmd}, {30'd0, p_cmd});
      chk("hold_wdata", {24'd0, eng_wdata}, {24'd0, p_wdata});
    end
    s_valid = eng_valid; s_accept = eng_valid & eng_ready; s_cmd = eng_cmd;
    s_wdata = eng_wdata; s_nl = eng_nack_last; s_pop = tx_pop; s_txd = tx_data;
    s_push = rx_push; s_rxd = rx_data; s_busy = busy;
    s_done_f = done_flag; s_nack_f = nack_flag; s_arb_f = arb_flag;
  endtask

  // Transaction-level model: what the bus and FIFOs should see.
  task automatic build_exp(logic rw, logic [6:0] addr, int cnt, int nk);
    cmd_rec_t r;
    exp_cmds.delete(); exp_pops.delete(); exp_push.delete();
    r = '{cmd: c_start, wdata: 8'h00, nl: 1'b0};  exp_cmds.push_back(r);
    r = '{cmd: c_write, wdata: {addr, rw}, nl: 1'b0}; exp_cmds.push_back(r);
    exp_nack = (nk == 0);
    if (!exp_nack) begin
      for (int i = 0; i < cnt; i++) begin
        if (!rw) begin
          r = '{cmd: c_write, wdata: txsrc[i], nl: 1'b0}; exp_cmds.push_back(r);
          exp_pops.push_back(txsrc[i]);
          if (nk == i + 1) begin exp_nack = 1; break; end
        end else begin
          r = '{cmd: c_read, wdata: 8'h00, nl: (i == cnt - 1)}; exp_cmds.push_back(r);
          exp_push.push_back(rxsrc[i]);
        end
      end
    end
    r = '{cmd: c_stop, wdata: 8'h00, nl: 1'b0}; exp_cmds.push_back(r);
  endtask

  task automatic start_txn(logic rw, logic [6:0] addr, int cnt, int nk);
    cmdlog.delete(); popped.delete(); pushed.delete();
    tx_q = txsrc; rd_q = rxsrc; nack_idx = nk;
    build_exp(rw, addr, cnt, nk);
    tick(); status_clear = 1; tick();
    cfg_rw = rw; cfg_addr = addr; cfg_count = CNT_W'(cnt); go = 1;
    tick();
    chk("busy_after_go", {31'd0, s_busy}, 32'd1);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (s_busy && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: busy still 1 after %0d cycles, expected 0", tag, n);
    end
  endtask

  task automatic wait_cmds(string tag, int k, bit need_done);
    int n = 0;
    while (!(cmdlog.size() >= k && (!need_done || !eng_busy)) && n < 1000) begin tick(); n++; end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.wait: %0d commands after %0d cycles, expected %0d", tag, cmdlog.size(), n, k);
    end
  endtask

  task automatic check_txn(string tag, logic e_done, logic e_arb);
    chk({tag, ".ncmd"}, cmdlog.size(), exp_cmds.size());
    for (int i = 0; i < cmdlog.size() && i < exp_cmds.size(); i++) begin
      chk($sformatf("%s.cmd%0d", tag, i), {30'd0, cmdlog[i].cmd}, {30'd0, exp_cmds[i].cmd});
      if (exp_cmds[i].cmd == c_write)
        chk($sformatf("%s.wdata%0d", tag, i), {24'd0, cmdlog[i].wdata}, {24'd0, exp_cmds[i].wdata});
      chk($sformatf("%s.nlast%0d", tag, i), {31'd0, cmdlog[i].nl}, {31'd0, exp_cmds[i].nl});
    end
    chk({tag, ".npop"}, popped.size(), exp_pops.size());
    for (int i = 0; i < popped.size() && i < exp_pops.size(); i++)
      chk($sformatf("%s.pop%0d", tag, i), {24'd0, popped[i]}, {24'd0, exp_pops[i]});
    chk({tag, ".npush"}, pushed.size(), exp_push.size());
    for (int i = 0; i < pushed.size() && i < exp_push.size(); i++)
      chk($sformatf("%s.push%0d", tag, i), {24'd0, pushed[i]}, {24'd0, exp_push[i]});
    chk({tag, ".done_flag"}, {31'd0, s_done_f}, {31'd0, e_done});
    chk({tag, ".nack_flag"}, {31'd0, s_nack_f}, {31'd0, exp_nack});
    chk({tag, ".arb_flag"}, {31'd0, s_arb_f}, {31'd0, e_arb});
  endtask

  vec_t tbl[6];

  initial begin
    int v;
    // ---------------- reset state ----------------
    #22;
    chk("rst.busy", {31'd0, busy}, 0);       chk("rst.eng_valid", {31'd0, eng_valid}, 0);
    chk("rst.tx_pop", {31'd0, tx_pop}, 0);   chk("rst.rx_push", {31'd0, rx_push}, 0);
    chk("rst.done", {31'd0, done_flag}, 0);  chk("rst.nack", {31'd0, nack_flag}, 0);
    chk("rst.arb", {31'd0, arb_flag}, 0);    chk("rst.rx_data", {24'd0, rx_data}, 0);
    chk("rst.eng_cmd", {30'd0, eng_cmd}, 0); chk("rst.eng_wdata", {24'd0, eng_wdata}, 0);
    chk("rst.nack_last", {31'd0, eng_nack_last}, 0);
    @(negedge pclk); n_rst = 1;

    // ---------------- vector table ----------------
    tbl[0] = '{1'b0, 7'h50, 2, -1, 5, 2, 0, 1'b0}; // write 2
    tbl[1] = '{1'b1, 7'h50, 3, -1, 6, 0, 3, 1'b0}; // read 3
    tbl[2] = '{1'b0, 7'h50, 2,  0, 3, 0, 0, 1'b1}; // address NACK
    tbl[3] = '{1'b0, 7'h2A, 0, -1, 3, 0, 0, 1'b0}; // address-only probe
    tbl[4] = '{1'b0, 7'h13, 3,  2, 5, 2, 0, 1'b1}; // NACK on 2nd data byte
    tbl[5] = '{1'b1, 7'h7F, 2,  0, 3, 0, 0, 1'b1}; // read, address NACK
    txsrc = '{8'hA5, 8'h3C, 8'h77};
    rxsrc = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 6; k++) begin
      string t;
      t = $sformatf("vec%0d", k);
      start_txn(tbl[k].rw, tbl[k].addr, tbl[k].cnt, tbl[k].nk);
      wait_idle(t);
      chk({t, ".tbl_ncmd"}, cmdlog.size(), tbl[k].e_ncmd);
      chk({t, ".tbl_pops"}, popped.size(), tbl[k].e_pops);
      chk({t, ".tbl_push"}, pushed.size(), tbl[k].e_push);
      chk({t, ".tbl_nack"}, {31'd0, s_nack_f}, {31'd0, tbl[k].e_nack});
      check_txn(t, 1'b1, 1'b0);
    end

    // ---------------- TX FIFO empty stall ----------------
    txsrc = '{8'h5A}; rxsrc = '{};
    start_txn(1'b0, 7'h50, 1, -1);
    tx_q.delete();
    wait_cmds("txe", 2, 1'b1);
    v = 0;
    repeat (10) begin tick(); if (s_valid) v++; end
    chk("txe.valid_cycles", v, 0);
    chk("txe.busy", {31'd0, s_busy}, 1);
    chk("txe.no_pop", popped.size(), 0);
    tx_q.push_back(8'h5A);
    wait_idle("txe");
    check_txn("txe", 1'b1, 1'b0);

    // ---------------- RX FIFO full stall ----------------
    txsrc = '{}; rxsrc = '{8'h11};
    start_txn(1'b1, 7'h50, 1, -1);
    wait_cmds("rxf", 3, 1'b1);
    rx_full = 1; rx_full_cnt = 5;
    repeat (5) tick();
    chk("rxf.no_push", pushed.size(), 0);
    chk("rxf.busy", {31'd0, s_busy}, 1);
    wait_idle("rxf");
    check_txn("rxf", 1'b1, 1'b0);

    // ---------------- arbitration lost in WR_WT, clear in same cycle ----------------
    done_lat = 40;
    txsrc = '{8'hA5, 8'h3C}; rxsrc = '{};
    start_txn(1'b0, 7'h50, 2, -1);
    wait_cmds("arb", 3, 1'b0);
    eng_arb_lost = 1; status_clear = 1;
    tick();
    chk("arb.busy", {31'd0, s_busy}, 0);
    chk("arb.flag", {31'd0, s_arb_f}, 1);
    repeat (5) tick();
    chk("arb.no_stop", cmdlog.size(), 3);
    chk("arb.done_flag", {31'd0, s_done_f}, 0);
    chk("arb.flag_sticky", {31'd0, s_arb_f}, 1);
    done_lat = 0;

    // ---------------- abort during WR_WT; go while busy ignored ----------------
    txsrc = '{8'h11, 8'h22, 8'h33}; rxsrc = '{};
    start_txn(1'b0, 7'h33, 3, -1);
    build_exp(1'b0, 7'h33, 1, -1);
    wait_cmds("abt", 3, 1'b0);
    abort = 1; go = 1; cfg_rw = 1; cfg_count = 6'd5;
    wait_idle("abt");
    check_txn("abt", 1'b1, 1'b0);

    // ---------------- reset mid-transaction ----------------
    txsrc = '{8'hA5, 8'h3C}; rxsrc = '{};
    start_txn(1'b0, 7'h50, 2, -1);
    wait_cmds("rmid", 3, 1'b0);
    #2 n_rst = 0; #1;
    chk("rmid.busy", {31'd0, busy}, 0);
    chk("rmid.valid", {31'd0, eng_valid}, 0);
    eng_busy = 0; eng_done = 0; eng_ready = 0;
    @(negedge pclk); n_rst = 1;
    repeat (5) tick();
    chk("rmid.no_stop", cmdlog.size(), 3);
    chk("rmid.done_flag", {31'd0, s_done_f}, 0);

    // ---------------- randomized transactions ----------------
    stall_rand = 1;
    for (int k = 0; k < 40; k++) begin
      logic rw;
      int cnt, nk;
      rw  = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 5);
      nk  = -1;
      if ($urandom_range(0, 3) == 0) nk = rw ? 0 : int'($urandom_range(0, cnt));
      txsrc.delete(); rxsrc.delete();
      for (int i = 0; i < cnt; i++) begin
        txsrc.push_back(8'($urandom));
        rxsrc.push_back(8'($urandom));
      end
      start_txn(rw, 7'($urandom), cnt, nk);
      wait_idle($sformatf("rnd%0d", k));
      check_txn($sformatf("rnd%0d", k), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_i2c_transaction_sequencer
`default_nettype wire
